// File: rtl/pqrs_chk_pkg.sv
// Shared types and constants for the p/q/r/s truth-table checker.
package pqrs_chk_pkg;
    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;
    localparam int ERR_W   = 5;

    localparam logic [NUM_VEC-1:0] GOLDEN_T = 16'h4644;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/pqrs_dwell_timer.sv
// Dwell counter: tick is high on the last cycle of each HOLD_CYCLES-long dwell.
module pqrs_dwell_timer #(
    parameter int HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    logic [7:0] cnt;

    assign tick = enable && (cnt == 8'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/pqrs_vector_checker.sv
// Steps {p,q,r,s} through all 16 vectors and checks t_in against a golden table.
// Define PQRS_OBSERVED_TABLE_EN to add the observed[15:0] captured-table output.
module pqrs_vector_checker
    import pqrs_chk_pkg::*;
#(
    parameter int                 HOLD_CYCLES = 20,
    parameter logic [NUM_VEC-1:0] EXPECTED    = GOLDEN_T
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             t_in,
    output logic             p_out,
    output logic             q_out,
    output logic             r_out,
    output logic             s_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_valid
`ifdef PQRS_OBSERVED_TABLE_EN
    ,
    output logic [NUM_VEC-1:0] observed
`endif
);
    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("pqrs_vector_checker: HOLD_CYCLES must be in 2..255");
    end

    state_t             state, state_d;
    logic [VEC_W-1:0]   idx;
    logic               accept, tick, mismatch, last;
    logic [ERR_W-1:0]   err_next;

    // The index doubles as the driven vector: it is 0 in IDLE/DONE.
    assign {p_out, q_out, r_out, s_out} = idx;

    assign accept   = start && (state != DRIVE);
    assign last     = (idx == VEC_W'(NUM_VEC - 1));
    assign mismatch = tick && (t_in != EXPECTED[idx]);
    assign err_next = err_count + ERR_W'(mismatch);

    pqrs_dwell_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (state == DRIVE),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: if (start) state_d = DRIVE;
            DRIVE:      if (tick && last) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else if (accept) begin
            idx        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else if (tick) begin
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
                first_fail <= idx;
                fail_valid <= 1'b1;
            end
            // pass uses err_next so a miss on vector 15 is not lost.
            if (last) begin
                idx  <= '0;
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_next == '0);
            end else begin
                idx <= idx + VEC_W'(1);
            end
        end
    end

`ifdef PQRS_OBSERVED_TABLE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      observed      <= '0;
        else if (accept) observed      <= '0;
        else if (tick)   observed[idx] <= t_in;
    end
`endif
endmodule
